btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
Multi-channel front end for the vending machine's push-buttons (coin/select inputs). It synchronizes each noisy button to CLK50M and debounces it with a per-channel stability counter. It emits a debounced level plus one-cycle press/release strobes. Sits directly upstream of the flip-flop/FSM stages. Downstream logic clocks on CLK50M and uses BTN_press as an enable, never as a clock.

Parameters:
N_BTN, 3, number of independent button channels
DEBOUNCE_CYCLES, 500000, consecutive post-sync cycles an input must hold a new value before it is accepted (10 ms at 50 MHz); legal range >= 1
CNT_W, 20, counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES

Ports:
CLK50M  input  1  system clock, 50 MHz; all state updates on rising edge
RST  input  1  synchronous, active-high reset
BTN_noisy  input  N_BTN  raw asynchronous button inputs, bit i = channel i
BTN_level  output  N_BTN  debounced, registered button level
BTN_press  output  N_BTN  one-cycle strobe when BTN_level[i] goes 0->1
BTN_release  output  N_BTN  one-cycle strobe when BTN_level[i] goes 1->0
ANY_press  output  1  OR of all BTN_press bits, same cycle as the strobes

Behaviour:
- Reset: on a rising edge with RST=1, the following all go to 0: sync stages, counters, BTN_level, BTN_press, BTN_release. ANY_press=0 follows from BTN_press. RST takes priority over every other update.
- Per channel, a 2-FF synchronizer: sync1<=BTN_noisy[i], sync2<=sync1. Only sync2 feeds the debounce logic.
- Per-channel counter cnt. On each edge:
  - sync2==BTN_level[i]: cnt<=0, no strobe. A bounce back restarts qualification.
  - sync2!=BTN_level[i] and cnt!=DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - sync2!=BTN_level[i] and cnt==DEBOUNCE_CYCLES-1: BTN_level[i]<=sync2, cnt<=0. On the same edge, BTN_press[i]<=sync2 and BTN_release[i]<=~sync2.
- Strobes are registered. They are high for exactly one cycle, coincident with the first cycle of the new BTN_level value. On every other edge they are 0.
- Latency: take an input held stable from the edge where it is first sampled (edge 0). BTN_level changes after edge DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)-th sampling edge. The same holds for the falling direction.
- Glitch rejection: a change that persists fewer than DEBOUNCE_CYCLES consecutive sync2 cycles produces no level change and no strobe.
- DEBOUNCE_CYCLES=1: the level follows sync2 with one extra register stage. Every accepted change still strobes.
- Channels are fully independent. Multiple press/release bits may assert in the same cycle. ANY_press=1 if any BTN_press bit is 1.
- Reset mid-qualification: the count is discarded. If a button is still held after RST deasserts, it requalifies from the first post-reset sample. BTN_press then fires DEBOUNCE_CYCLES+2 edges after reset release. A press is never lost, and never doubled.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.

Test Plan (N_BTN=3, DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset: hold BTN_noisy=3'b111, RST=1 for 3 edges. Require all outputs 0 throughout. Release RST; require BTN_level=3'b111 and BTN_press=3'b111 for exactly one cycle after the 6th edge, then BTN_press=0.
- Clean press ch0: BTN_noisy[0] 0->1, first sampled at edge 0. Require BTN_level[0]=1 and BTN_press[0]=1 after edge 5, ANY_press=1 that cycle, BTN_press[0]=0 after edge 6.
- Bounce reject: BTN_noisy[1] high for 3 cycles, low 1, high 2, low. Require BTN_level[1]=0 and no strobes on any channel.
- Bounce then settle ch2: pattern 1,0,1,1,1,1 (held). Require a single BTN_press[2] pulse 5 edges after the last 0->1 sample, not earlier.
- Release: from BTN_level[0]=1, drive BTN_noisy[0]=0 held. Require BTN_release[0]=1 for one cycle after edge 5, BTN_level[0]=0, no BTN_press.
- Simultaneous + reset mid-op: press ch0 and ch1 on the same edge. Require BTN_press=3'b011 in one cycle. Repeat with RST pulsed at count 2. Require no strobe at the original time and a single 3'b011 strobe 6 edges after RST deasserts.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw buttons in,
// debounced level and edge strobes out.
interface btn_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] BTN_noisy;
  logic [N_BTN-1:0] BTN_level;
  logic [N_BTN-1:0] BTN_press;
  logic [N_BTN-1:0] BTN_release;
  logic             ANY_press;

  modport master (
    output BTN_noisy,
    input  BTN_level,
    input  BTN_press,
    input  BTN_release,
    input  ANY_press
  );

  modport slave (
    input  BTN_noisy,
    output BTN_level,
    output BTN_press,
    output BTN_release,
    output ANY_press
  );
endinterface

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: 2-FF sync,
// per-channel stability-counter debounce, press/release strobes.
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              CLK50M,
  input  logic              RST,
  btn_conditioner_if.slave  btn
);

  localparam logic [CNT_W-1:0] CntMax =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] release_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // A mismatch must persist DEBOUNCE_CYCLES edges; any
  // agreement with the current level restarts qualification.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] != CntMax) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn.BTN_noisy;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn.BTN_level   = level_q;
  assign btn.BTN_press   = press_q;
  assign btn.BTN_release = release_q;
  assign btn.ANY_press   = |press_q;

endmodule
